// File: rtl/pattern_seq_pkg.sv
// Shared constants and types for the pattern sequencer controller.
// Holds the FSM encodings, status word layout and default datapath sizes.
package pattern_seq_pkg;

  localparam int unsigned ADDR_W_DEF      = 10;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned BLOCK_WORDS_DEF = 256;
  localparam int unsigned REP_W           = 16;
  localparam int unsigned STATUS_W        = 16;
  localparam int unsigned LCNT_W          = 11;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_PREFETCH = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_LOADED   = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_COL      = 3;
  localparam int unsigned STAT_EMPTY    = 4;
  localparam int unsigned STAT_CNT_LSB  = 5;

  // Status WireOut payload, MSB first.
  typedef struct packed {
    logic [LCNT_W-1:0] load_count;
    logic              empty_start;
    logic              collision;
    logic              overflow;
    logic              loaded;
    logic              busy;
  } status_t;

endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// Single-port pattern RAM bus between the sequencer controller and the RAM.
interface pattern_seq_ctrl_if
  import pattern_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_we, output ram_addr, output ram_wdata, input ram_rdata);
  modport slave  (input ram_we, input ram_addr, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/pattern_ram.sv
// Single-port synchronous-read pattern RAM, DEPTH x DATA_W.
// Instantiated alongside the controller by the enclosing user module.
module pattern_ram
  import pattern_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  pattern_seq_ctrl_if.slave  ram
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_wdata;
    ram.ram_rdata <= mem[ram.ram_addr];
  end
endmodule

// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer controller: loads PipeIn words into RAM, replays them
// cfg_repeat times under TriggerIn control, and owns the single RAM port.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     cfg_len,
  input  logic [REP_W-1:0]      cfg_repeat,
  input  logic                  trig_start,
  input  logic                  trig_stop,
  input  logic                  trig_load,
  input  logic                  pipe_write,
  input  logic [DATA_W-1:0]     pipe_data,
  output logic                  pipe_ready,
  pattern_seq_ctrl_if.master    ram,
  output logic [DATA_W-1:0]     pat_out,
  output logic                  pat_valid,
  output logic                  done_pulse,
  output logic [STATUS_W-1:0]   status
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [1:0]        state, state_n;
  logic [CNT_W-1:0]  wr_ptr, wr_ptr_n, lc_m1, free_n;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_n, len_q, len_n;
  logic [REP_W-1:0]  rep_q, rep_n, pass_q, pass_n;
  logic              issue_done_q, issue_done_n;
  logic              last_q, last_n;
  logic              ovf_q, ovf_n, col_q, col_n, empty_q, empty_n;
  logic              we_c;
  logic              pat_valid_n, done_n, pipe_ready_n;
  logic [DATA_W-1:0] pat_out_n;
  status_t           status_n;

  // State register and all registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len_q        <= '0;
      rep_q        <= '0;
      pass_q       <= '0;
      issue_done_q <= 1'b0;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      col_q        <= 1'b0;
      empty_q      <= 1'b0;
      pat_out      <= '0;
      pat_valid    <= 1'b0;
      done_pulse   <= 1'b0;
      pipe_ready   <= 1'b0;
      status       <= '0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      len_q        <= len_n;
      rep_q        <= rep_n;
      pass_q       <= pass_n;
      issue_done_q <= issue_done_n;
      last_q       <= last_n;
      ovf_q        <= ovf_n;
      col_q        <= col_n;
      empty_q      <= empty_n;
      pat_out      <= pat_out_n;
      pat_valid    <= pat_valid_n;
      done_pulse   <= done_n;
      pipe_ready   <= pipe_ready_n;
      status       <= status_n;
    end
  end

  // Next-state, pointer, flag and output logic.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    len_n        = len_q;
    rep_n        = rep_q;
    pass_n       = pass_q;
    issue_done_n = issue_done_q;
    last_n       = 1'b0;
    ovf_n        = ovf_q;
    col_n        = col_q;
    empty_n      = empty_q;
    we_c         = 1'b0;
    done_n       = last_q;
    lc_m1        = wr_ptr - CNT_W'(1);

    case (state)
      S_IDLE, S_LOAD: begin
        if (trig_load) begin
          state_n  = S_IDLE;
          wr_ptr_n = '0;
          ovf_n    = 1'b0;
          col_n    = 1'b0;
          empty_n  = 1'b0;
        end else begin
          if (pipe_write) begin
            state_n = S_LOAD;
            if (wr_ptr == CNT_W'(DEPTH)) begin
              ovf_n = 1'b1;
            end else begin
              we_c     = 1'b1;
              wr_ptr_n = wr_ptr + CNT_W'(1);
            end
          end
          // A simultaneous stop cancels the start.
          if (trig_start && !trig_stop) begin
            if (wr_ptr == '0) begin
              empty_n = 1'b1;
            end else begin
              state_n      = S_PREFETCH;
              len_n        = (CNT_W'(cfg_len) < lc_m1) ? cfg_len : ADDR_W'(lc_m1);
              rep_n        = cfg_repeat;
              rd_ptr_n     = '0;
              pass_n       = REP_W'(1);
              issue_done_n = 1'b0;
            end
          end
        end
      end
      default: begin
        if (pipe_write) col_n = 1'b1;
        if (trig_stop) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (issue_done_q) begin
          // Final read is in flight; its word reaches pat_out on this edge.
          state_n = S_IDLE;
          last_n  = 1'b1;
        end else begin
          state_n = S_RUN;
          if (rd_ptr == len_q) begin
            rd_ptr_n = '0;
            if (rep_q != '0 && pass_q == rep_q) issue_done_n = 1'b1;
            else                                pass_n       = pass_q + REP_W'(1);
          end else begin
            rd_ptr_n = rd_ptr + ADDR_W'(1);
          end
        end
      end
    endcase

    pat_valid_n  = (state == S_RUN) && !trig_stop;
    pat_out_n    = pat_valid_n ? ram.ram_rdata : pat_out;
    free_n       = CNT_W'(DEPTH) - wr_ptr_n;
    pipe_ready_n = ((state_n == S_IDLE) || (state_n == S_LOAD)) &&
                   (free_n >= CNT_W'(BLOCK_WORDS));

    status_n.busy        = (state_n == S_PREFETCH) || (state_n == S_RUN);
    status_n.loaded      = (wr_ptr_n != '0);
    status_n.overflow    = ovf_n;
    status_n.collision   = col_n;
    status_n.empty_start = empty_n;
    status_n.load_count  = LCNT_W'(wr_ptr_n);
  end

  // Loader owns the RAM port only on the cycle it writes.
  assign ram.ram_we    = we_c;
  assign ram.ram_addr  = we_c ? ADDR_W'(wr_ptr) : rd_ptr;
  assign ram.ram_wdata = we_c ? pipe_data : '0;

endmodule
